// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB,
// ALU source selection and load-use hazard detection.
module ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [3:0]         id_alu_ctrl,
    input  logic [1:0]         id_src1_sel,
    input  logic [1:0]         id_src2_sel,
    input  logic               id_reg_write,
    input  logic               id_is_load,
    input  logic               id_is_store,
    input  logic               id_is_branch,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    alu_in1,
    output logic [XLEN-1:0]    alu_in2,
    output logic [3:0]         alu_ctrl,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_is_load,
    output logic               ex_is_store,
    output logic               ex_is_branch,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_store_data,
    output logic               load_use_hazard
);

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]         alu_ctrl_q, alu_ctrl_d;
    logic [1:0]         src1_sel_q, src1_sel_d;
    logic [1:0]         src2_sel_q, src2_sel_d;
    logic               reg_write_q, reg_write_d;
    logic               is_load_q, is_load_d;
    logic               is_store_q, is_store_d;
    logic               is_branch_q, is_branch_d;

    logic [XLEN-1:0]    rs1_fwd;
    logic [XLEN-1:0]    rs2_fwd;

    // Flush, or an empty ID slot when not stalled, loads an all-zero bubble.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_ctrl_d  = alu_ctrl_q;
        src1_sel_d  = src1_sel_q;
        src2_sel_d  = src2_sel_q;
        reg_write_d = reg_write_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        is_branch_d = is_branch_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rd_addr_d   = '0;
            alu_ctrl_d  = '0;
            src1_sel_d  = '0;
            src2_sel_d  = '0;
            reg_write_d = 1'b0;
            is_load_d   = 1'b0;
            is_store_d  = 1'b0;
            is_branch_d = 1'b0;
        end else if (!stall) begin
            valid_d     = 1'b1;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rd_addr_d   = id_rd_addr;
            alu_ctrl_d  = id_alu_ctrl;
            src1_sel_d  = id_src1_sel;
            src2_sel_d  = id_src2_sel;
            reg_write_d = id_reg_write;
            is_load_d   = id_is_load;
            is_store_d  = id_is_store;
            is_branch_d = id_is_branch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_ctrl_q  <= '0;
            src1_sel_q  <= '0;
            src2_sel_q  <= '0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_ctrl_q  <= alu_ctrl_d;
            src1_sel_q  <= src1_sel_d;
            src2_sel_q  <= src2_sel_d;
            reg_write_q <= reg_write_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            is_branch_q <= is_branch_d;
        end
    end

    // The nearer stage (EX/MEM) holds the younger result and wins; x0 never forwards.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs1_addr_q))
            rs1_fwd = mem_fwd_data;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q))
            rs1_fwd = wb_data;

        rs2_fwd = rs2_data_q;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs2_addr_q))
            rs2_fwd = mem_fwd_data;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q))
            rs2_fwd = wb_data;
    end

    always_comb begin
        case (src1_sel_q)
            2'd1:    alu_in1 = pc_q;
            2'd2:    alu_in1 = '0;
            default: alu_in1 = rs1_fwd;
        endcase
        case (src2_sel_q)
            2'd1:    alu_in2 = imm_q;
            2'd2:    alu_in2 = XLEN'(4);
            default: alu_in2 = rs2_fwd;
        endcase
    end

    assign alu_ctrl      = valid_q ? alu_ctrl_q : 4'd0;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_is_load    = is_load_q;
    assign ex_is_store   = is_store_q;
    assign ex_is_branch  = is_branch_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_store_data = rs2_fwd;

    // rs2 is compared even for formats without rs2: a spurious stall is harmless.
    assign load_use_hazard = valid_q && is_load_q && (rd_addr_q != '0) && id_valid &&
                             ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));

endmodule
